// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake, registered result/flags and bit-serial shifts.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 8).
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       func_i,
  input  logic [WIDTH-1:0] a_imm_i,
  input  logic [WIDTH-1:0] a_mem_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             fz_o,
  output logic             fc_o,
  output logic             fn_o
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADI = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_ORR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [WIDTH-1:0] sh_q, sh_d;       // shift operand; multiplier / product low word in MUL
  logic [WIDTH-1:0] res_q, res_d;
  logic             fz_q, fz_d, fc_q, fc_d, fn_q, fn_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] wr_hi;
`endif

  logic [WIDTH:0]   sum;
  logic             wr_en, wr_c;
  logic [WIDTH-1:0] wr_res;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sh_next;
  logic             bit_out;

  assign amt     = b_i[SHW-1:0];
  assign sh_next = left_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
  assign bit_out = left_q ? sh_q[WIDTH-1] : sh_q[0];

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sh_d    = sh_q;
    res_d   = res_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    fn_d    = fn_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    res_hi_d = res_hi_q;
    wr_hi    = '0;
`endif
    sum    = '0;
    wr_en  = 1'b0;
    wr_c   = 1'b0;
    wr_res = '0;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          case (func_i)
            OP_ADI: begin
              sum    = {1'b0, b_i} + {1'b0, a_imm_i};
              wr_res = sum[WIDTH-1:0];
              wr_c   = sum[WIDTH];
            end
            OP_ADD: begin
              sum    = {1'b0, b_i} + {1'b0, a_mem_i};
              wr_res = sum[WIDTH-1:0];
              wr_c   = sum[WIDTH];
            end
            OP_SUB: begin
              // Zero-extended difference: the top bit is the unsigned borrow.
              sum    = {1'b0, b_i} - {1'b0, a_mem_i};
              wr_res = sum[WIDTH-1:0];
              wr_c   = sum[WIDTH];
            end
            OP_AND: wr_res = b_i & a_mem_i;
            OP_ORR: wr_res = b_i | a_mem_i;
            OP_XOR: wr_res = b_i ^ a_mem_i;
            OP_LSL, OP_LSR: begin
              if (amt == '0) begin
                wr_res = a_mem_i;
              end else begin
                state_d = S_SHIFT;
                wr_en   = 1'b0;
                sh_d    = a_mem_i;
                cnt_d   = CW'(amt);
                left_d  = (func_i == OP_LSL);
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              state_d = S_MUL;
              wr_en   = 1'b0;
              mcand_d = a_mem_i;
              sh_d    = b_i;
              hi_d    = '0;
              cnt_d   = CW'(WIDTH);
            end
`endif
            default: ;  // illegal opcode: zero result, zero flag set
          endcase
        end
      end
      S_SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          wr_res  = sh_next;
          wr_c    = bit_out;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        sum          = {1'b0, hi_q} + (sh_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        {hi_d, sh_d} = {sum, sh_q[WIDTH-1:1]};
        cnt_d        = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          wr_en   = 1'b1;
          wr_res  = sh_d;
          wr_hi   = hi_d;
          wr_c    = |hi_d;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      res_d = wr_res;
      fz_d  = (wr_res == '0);
      fn_d  = wr_res[WIDTH-1];
      fc_d  = wr_c;
`ifdef ALU_SEQ_MUL_EN
      res_hi_d = wr_hi;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      sh_q    <= '0;
      res_q   <= '0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fn_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      hi_q     <= '0;
      res_hi_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      fn_q    <= fn_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      res_hi_q <= res_hi_d;
`endif
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = res_q;
  assign fz_o     = fz_q;
  assign fc_o     = fc_q;
  assign fn_o     = fn_q;
`ifdef ALU_SEQ_MUL_EN
  assign result_hi_o = res_hi_q;
`else
  assign result_hi_o = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): a driver pushes model predictions, a monitor
// checks every valid_o pulse for value, flags and completion edge.
module tb_alu_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [3:0] func_i = '0;
  logic [7:0] a_imm_i = '0, a_mem_i = '0, b_i = '0;
  logic       valid_o;
  logic [7:0] result_o, result_hi_o;
  logic       fz_o, fc_o, fn_o;

  alu_seq #(.WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .func_i(func_i), .a_imm_i(a_imm_i), .a_mem_i(a_mem_i), .b_i(b_i),
    .valid_o(valid_o), .result_o(result_o), .result_hi_o(result_hi_o),
    .fz_o(fz_o), .fc_o(fc_o), .fn_o(fn_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  res;
    logic [7:0]  hi;
    logic        fz, fc, fn;
    int unsigned lat;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned edge_cnt = 0;
  int          n_pulses = 0;
  int          n_issued = 0;
  logic [7:0]  last_res = '0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] ai,
                                 input logic [7:0] am, input logic [7:0] b);
    exp_t e;
    int   n, w;
    e.op = op; e.res = '0; e.hi = '0; e.fc = 1'b0; e.lat = 0; e.edge_no = 0;
    n = int'(b[2:0]);
    case (op)
      4'd0: begin w = int'(b) + int'(ai); e.res = w[7:0]; e.fc = (w > 255); end
      4'd1: begin w = int'(b) + int'(am); e.res = w[7:0]; e.fc = (w > 255); end
      4'd2: begin e.res = b - am; e.fc = (b < am); end
      4'd3: e.res = b & am;
      4'd4: e.res = b | am;
      4'd5: e.res = b ^ am;
      4'd6: begin e.res = am << n; e.fc = (n == 0) ? 1'b0 : am[8-n]; e.lat = n; end
      4'd7: begin e.res = am >> n; e.fc = (n == 0) ? 1'b0 : am[n-1]; e.lat = n; end
`ifdef ALU_SEQ_MUL_EN
      4'd8: begin
        w = int'(am) * int'(b);
        e.res = w[7:0]; e.hi = w[15:8]; e.fc = (w[15:8] != 0); e.lat = 8;
      end
`endif
      default: ;
    endcase
    e.fz = (e.res == 8'h00);
    e.fn = e.res[7];
    return e;
  endfunction

  // Drive a request and keep it asserted until accepted; predictions go to the scoreboard.
  task automatic send(input logic [3:0] op, input logic [7:0] ai, input logic [7:0] am,
                      input logic [7:0] b);
    exp_t e;
    int   budget;
    @(negedge clk_i);
    valid_i = 1'b1; func_i = op; a_imm_i = ai; a_mem_i = am; b_i = b;
    budget = 0;
    while (!ready_o && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    if (!ready_o) begin
      check("ready_o timeout", 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    e = model(op, ai, am, b);
    e.edge_no = edge_cnt + 1 + e.lat;
    sb.push_back(e);
    n_issued++;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk_i);
      budget++;
    end
    check("scoreboard drain", 32'(sb.size()), 32'd0);
    @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (valid_o) begin
      n_pulses++;
      if (sb.size() == 0) begin
        check("unexpected valid_o", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d result", e.op), 32'(result_o),    32'(e.res));
        check($sformatf("op%0d hi",     e.op), 32'(result_hi_o), 32'(e.hi));
        check($sformatf("op%0d fz",     e.op), 32'(fz_o),        32'(e.fz));
        check($sformatf("op%0d fc",     e.op), 32'(fc_o),        32'(e.fc));
        check($sformatf("op%0d fn",     e.op), 32'(fn_o),        32'(e.fn));
        check($sformatf("op%0d edge",   e.op), edge_cnt,         e.edge_no);
        last_res = e.res;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, " ready_o"},     32'(ready_o),     32'd1);
    check({tag, " valid_o"},     32'(valid_o),     32'd0);
    check({tag, " result_o"},    32'(result_o),    32'd0);
    check({tag, " result_hi_o"}, 32'(result_hi_o), 32'd0);
    check({tag, " flags"},       32'({fz_o, fc_o, fn_o}), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_state("reset");

    // Directed cases: arithmetic, flags, shifts, multiply boundaries.
    send(4'd0, 8'h01, 8'h00, 8'h00);
    send(4'd1, 8'h00, 8'h01, 8'hFF);
    send(4'd2, 8'h00, 8'h02, 8'h01);
    send(4'd2, 8'h00, 8'h01, 8'h01);
    send(4'd6, 8'h00, 8'h0C, 8'h03);
    send(4'd7, 8'h00, 8'h0D, 8'h01);
    send(4'd6, 8'h00, 8'hA5, 8'h00);
    send(4'd7, 8'h00, 8'h81, 8'h07);
    send(4'd8, 8'h00, 8'hFF, 8'hFF);
    send(4'd8, 8'h00, 8'h0F, 8'h11);
    send(4'd12, 8'h55, 8'hAA, 8'h33);
    // A request held while the shifter is busy, with new operands, must wait its turn.
    send(4'd6, 8'h00, 8'h0C, 8'h03);
    send(4'd1, 8'h00, 8'h10, 8'h20);
    drain();
    repeat (3) @(negedge clk_i);
    check("result hold", 32'(result_o), 32'(last_res));

    // Randomised mix across all opcodes.
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    drain();

    // Abort a long operation with a one-cycle reset: no pulse, outputs back to reset values.
`ifdef ALU_SEQ_MUL_EN
    send(4'd8, 8'h00, 8'h37, 8'h9B);
`else
    send(4'd6, 8'h00, 8'h37, 8'h07);
`endif
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    sb.delete();
    n_issued--;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_state("abort");
    repeat (12) @(negedge clk_i);
    send(4'd1, 8'h00, 8'h21, 8'h42);
    drain();

    check("pulse count", 32'(n_pulses), 32'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
